// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared widths, constants and FSM state encodings for the
//               instruction/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WE_W   = 4;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;
    // A byte-enable mask of all zeros marks a read access.
    localparam logic [WE_W-1:0]   WE_READ   = '0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DACC  = 2'd1;
    localparam logic [1:0] ST_IACC  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Any state other than IDLE owns an outstanding bus transaction.
    function automatic logic is_busy(input logic [1:0] st);
        return st != ST_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Shared memory port between the arbiter (master) and the
//               memory (slave). bus_ack is a one-cycle completion strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic [WE_W-1:0]   bus_we;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req,
        output bus_addr,
        output bus_we,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        input  bus_we,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_bus_timer
// Description : Wait counter for one bus transaction. Cleared while the
//               arbiter is idle, advanced on every cycle without bus_ack;
//               'expired' flags the last cycle allowed before abort.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_bus_timer #(
    parameter int TIMEOUT = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);

    localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count one waited cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates a CPU's instruction fetch and data ports onto one
//               shared memory port. Data beats fetch, a flushed fetch is
//               drained and discarded, and a silent memory is aborted after
//               TIMEOUT cycles with a one-cycle bus_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  wire logic              cpu_clk_50M,
    input  wire logic              cpu_rst_n,
    input  wire logic              ice,
    input  wire logic [ADDR_W-1:0] iaddr,
    output logic      [DATA_W-1:0] inst,
    input  wire logic              dce,
    input  wire logic [ADDR_W-1:0] daddr,
    input  wire logic [WE_W-1:0]   dwe,
    input  wire logic [DATA_W-1:0] din,
    output logic      [DATA_W-1:0] dout,
    input  wire logic              flush,
    output logic                   stallreq,
    output logic                   bus_err,
    mem_arbiter_if.master          bus
);

    logic [1:0]        state_q,     state_d;
    logic              bus_req_q,   bus_req_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [WE_W-1:0]   bus_we_q,    bus_we_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] inst_q,      inst_d;
    logic [DATA_W-1:0] dout_q,      dout_d;
    logic              bus_err_q,   bus_err_d;
    logic              timer_clr;
    logic              timer_en;
    logic              timer_expired;

    // The wait count restarts whenever the arbiter is idle, so it is zero on
    // the first cycle of every access and keeps running across IACC->DRAIN.
    assign timer_clr = (state_q == ST_IDLE);

    mem_arbiter_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timer (
        .clk     (cpu_clk_50M),
        .rst_n   (cpu_rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Next-state, bus-register and result logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_wdata_d = bus_wdata_q;
        inst_d      = inst_q;
        dout_d      = dout_q;
        bus_err_d   = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dce) begin
                    state_d     = ST_DACC;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = daddr;
                    bus_we_d    = dwe;
                    bus_wdata_d = din;
                end else if (ice && !flush) begin
                    state_d     = ST_IACC;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = iaddr;
                    bus_we_d    = WE_READ;
                    bus_wdata_d = ZERO_WORD;
                end
            end
            ST_DACC: begin
                if (bus.bus_ack) begin
                    if (bus_we_q == WE_READ) begin
                        dout_d = bus.bus_rdata;
                    end
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                end else if (timer_expired) begin
                    if (bus_we_q == WE_READ) begin
                        dout_d = ZERO_WORD;
                    end
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_IACC: begin
                if (bus.bus_ack) begin
                    // A flush arriving with the ack still discards the word.
                    if (!flush) begin
                        inst_d = bus.bus_rdata;
                    end
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                end else if (timer_expired) begin
                    inst_d    = ZERO_WORD;
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    timer_en = 1'b1;
                    if (flush) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.bus_ack) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                end else if (timer_expired) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access without a result.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_we_q    <= '0;
            bus_wdata_q <= '0;
            inst_q      <= ZERO_WORD;
            dout_q      <= ZERO_WORD;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_wdata_q <= bus_wdata_d;
            inst_q      <= inst_d;
            dout_q      <= dout_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Stall while an access is outstanding or about to be accepted; held low
    // during reset so every output reads zero.
    assign stallreq      = cpu_rst_n & (is_busy(state_q) | dce | ice);

    assign inst          = inst_q;
    assign dout          = dout_q;
    assign bus_err       = bus_err_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: a table of single
//               transactions, hand-written corner sequences, then random
//               traffic against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ice, dce, flush;
    logic [31:0] iaddr, daddr, din;
    logic [3:0]  dwe;
    logic [31:0] inst, dout;
    logic        stallreq, bus_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter_if bus_if ();

    mem_arbiter dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .ice         (ice),
        .iaddr       (iaddr),
        .inst        (inst),
        .dce         (dce),
        .daddr       (daddr),
        .dwe         (dwe),
        .din         (din),
        .dout        (dout),
        .flush       (flush),
        .stallreq    (stallreq),
        .bus_err     (bus_err),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_inst"},  inst, 32'h0);
        chk({tag, "_dout"},  dout, 32'h0);
        chk({tag, "_req"},   32'(bus_if.bus_req), 32'h0);
        chk({tag, "_addr"},  bus_if.bus_addr, 32'h0);
        chk({tag, "_we"},    32'(bus_if.bus_we), 32'h0);
        chk({tag, "_wdata"}, bus_if.bus_wdata, 32'h0);
        chk({tag, "_err"},   32'(bus_err), 32'h0);
        chk({tag, "_stall"}, 32'(stallreq), 32'h0);
    endtask

    // One isolated transaction with a memory that answers after wait_n
    // cycles (wait_n >= T means it never answers).
    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] rdata;
        logic [31:0] exp_inst;
        logic [31:0] exp_dout;
        bit          exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        dce   = v.is_data;
        ice   = !v.is_data;
        daddr = v.addr;
        iaddr = v.addr;
        dwe   = v.is_data ? v.we : 4'h0;
        din   = v.wdata;
        flush = 1'b0;
        #1 chk("vec_stall_accept", 32'(stallreq), 32'h1);
        for (int n = 0; n < T; n++) begin
            @(negedge clk);
            dce = 1'b0;
            ice = 1'b0;
            chk("vec_bus_req", 32'(bus_if.bus_req), 32'h1);
            chk("vec_bus_addr", bus_if.bus_addr, v.addr);
            chk("vec_bus_we", 32'(bus_if.bus_we), v.is_data ? 32'(v.we) : 32'h0);
            if (v.is_data) chk("vec_bus_wdata", bus_if.bus_wdata, v.wdata);
            #1 chk("vec_stall_busy", 32'(stallreq), 32'h1);
            if (n == v.wait_n) begin
                bus_if.bus_ack   = 1'b1;
                bus_if.bus_rdata = v.rdata;
                break;
            end
        end
        @(negedge clk);
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        chk("vec_req_drop", 32'(bus_if.bus_req), 32'h0);
        chk("vec_inst", inst, v.exp_inst);
        chk("vec_dout", dout, v.exp_dout);
        chk("vec_bus_err", 32'(bus_err), 32'(v.exp_err));
        #1 chk("vec_stall_release", 32'(stallreq), 32'h0);
        @(negedge clk);
        chk("vec_bus_err_pulse_end", 32'(bus_err), 32'h0);
    endtask

    // Transaction-level reference model for the random phase.
    bit          m_busy, m_fetch, m_discard, m_err;
    int          m_waited, m_target;
    logic [31:0] m_addr, m_wdata, m_inst, m_dout;
    logic [3:0]  m_we;
    logic [31:0] mem [16];

    function automatic int pick_wait();
        int r = $urandom_range(0, 11);
        if (r == 0) return T + 2;
        if (r == 1) return T - 1;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        rst_n = 1'b0;
        ice = 1'b1; dce = 1'b1; flush = 1'b0;
        iaddr = 32'h100; daddr = 32'h200; dwe = 4'hF; din = 32'h55AA55AA;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = 32'h0;

        // Reset state, with requests held active.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        ice = 1'b0; dce = 1'b0; dwe = 4'h0;
        rst_n = 1'b1;

        // Table of isolated transactions.
        vecs[0] = '{1'b0, 32'h00000040, 4'h0, 32'h0,        2,     32'h24020005, 32'h24020005, 32'h00000000, 1'b0};
        vecs[1] = '{1'b1, 32'h80000010, 4'h0, 32'h0,        0,     32'hCAFEF00D, 32'h24020005, 32'hCAFEF00D, 1'b0};
        vecs[2] = '{1'b1, 32'h80000020, 4'h3, 32'hDEADBEEF, 1,     32'h11111111, 32'h24020005, 32'hCAFEF00D, 1'b0};
        vecs[3] = '{1'b1, 32'h80000030, 4'h0, 32'h0,        3,     32'hA5A5A5A5, 32'h24020005, 32'hA5A5A5A5, 1'b0};
        vecs[4] = '{1'b0, 32'h00000044, 4'h0, 32'h0,        T,     32'h99999999, 32'h00000000, 32'hA5A5A5A5, 1'b1};
        vecs[5] = '{1'b1, 32'h80000034, 4'h0, 32'h0,        T,     32'h99999999, 32'h00000000, 32'h00000000, 1'b1};
        vecs[6] = '{1'b0, 32'h00000048, 4'h0, 32'h0,        1,     32'h8C220004, 32'h8C220004, 32'h00000000, 1'b0};
        vecs[7] = '{1'b1, 32'h80000038, 4'hF, 32'h01020304, T,     32'h99999999, 32'h8C220004, 32'h00000000, 1'b1};
        vecs[8] = '{1'b1, 32'h8000003C, 4'h0, 32'h0,        T - 1, 32'h0F0F0F0F, 32'h8C220004, 32'h0F0F0F0F, 1'b0};
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Simultaneous data read and fetch: data goes first.
        @(negedge clk);
        dce = 1'b1; daddr = 32'h80000010; dwe = 4'h0;
        ice = 1'b1; iaddr = 32'h00000050;
        @(negedge clk);
        chk("sim_first_req", 32'(bus_if.bus_req), 32'h1);
        chk("sim_first_addr", bus_if.bus_addr, 32'h80000010);
        dce = 1'b0;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h13579BDF;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        chk("sim_dout", dout, 32'h13579BDF);
        chk("sim_gap_req", 32'(bus_if.bus_req), 32'h0);
        #1 chk("sim_gap_stall", 32'(stallreq), 32'h1);
        @(negedge clk);
        chk("sim_fetch_req", 32'(bus_if.bus_req), 32'h1);
        chk("sim_fetch_addr", bus_if.bus_addr, 32'h00000050);
        chk("sim_fetch_we", 32'(bus_if.bus_we), 32'h0);
        ice = 1'b0;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h2468ACE0;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        chk("sim_inst", inst, 32'h2468ACE0);

        // Flush during a fetch: the transaction drains, the word is dropped.
        @(negedge clk);
        ice = 1'b1; iaddr = 32'h00000060;
        @(negedge clk);
        chk("flush_req", 32'(bus_if.bus_req), 32'h1);
        ice = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("drain_req_held", 32'(bus_if.bus_req), 32'h1);
        #1 chk("drain_stall", 32'(stallreq), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("drain_addr_held", bus_if.bus_addr, 32'h00000060);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h12345678;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        chk("flush_inst_kept", inst, 32'h2468ACE0);
        chk("flush_req_drop", 32'(bus_if.bus_req), 32'h0);
        #1 chk("flush_stall", 32'(stallreq), 32'h0);

        // Reset mid-fetch, then a late ack that must be ignored.
        @(negedge clk);
        ice = 1'b1; iaddr = 32'h00000070;
        @(negedge clk);
        chk("rstmid_req", 32'(bus_if.bus_req), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rstmid");
        @(negedge clk);
        ice = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEADDEAD;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        chk_all_zero("late_ack");

        // Random traffic against the reference model.
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_busy = 0; m_fetch = 0; m_discard = 0; m_err = 0;
        m_waited = 0; m_target = 0;
        m_addr = 0; m_wdata = 0; m_we = 0; m_inst = 0; m_dout = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_bus_req", 32'(bus_if.bus_req), 32'(m_busy));
            if (m_busy) begin
                chk("rnd_bus_addr", bus_if.bus_addr, m_addr);
                chk("rnd_bus_we", 32'(bus_if.bus_we), m_fetch ? 32'h0 : 32'(m_we));
                if (!m_fetch) chk("rnd_bus_wdata", bus_if.bus_wdata, m_wdata);
            end
            chk("rnd_inst", inst, m_inst);
            chk("rnd_dout", dout, m_dout);
            chk("rnd_bus_err", 32'(bus_err), 32'(m_err));

            if (m_busy) begin
                bus_if.bus_ack   = (m_waited == m_target);
                bus_if.bus_rdata = bus_if.bus_ack ? mem[m_addr[5:2]] : $urandom;
            end else begin
                bus_if.bus_ack   = ($urandom_range(0, 15) == 0);
                bus_if.bus_rdata = $urandom;
            end
            dce   = ($urandom_range(0, 3) == 0);
            ice   = $urandom_range(0, 1) == 1;
            flush = ($urandom_range(0, 7) == 0);
            daddr = $urandom;
            iaddr = $urandom & 32'hFFFF_FFFC;
            dwe   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            din   = $urandom;
            #1 chk("rnd_stallreq", 32'(stallreq), 32'(m_busy || dce || ice));

            m_err = 0;
            if (!m_busy) begin
                if (dce || (ice && !flush)) begin
                    m_busy    = 1;
                    m_fetch   = !dce;
                    m_discard = 0;
                    m_addr    = dce ? daddr : iaddr;
                    m_we      = dce ? dwe : 4'h0;
                    m_wdata   = din;
                    m_waited  = 0;
                    m_target  = pick_wait();
                end
            end else if (bus_if.bus_ack) begin
                if (m_fetch) begin
                    if (!m_discard && !flush) m_inst = bus_if.bus_rdata;
                end else if (m_we == 4'h0) begin
                    m_dout = bus_if.bus_rdata;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (m_we[b]) mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
                end
                m_busy = 0;
            end else if (m_waited == T - 1) begin
                m_err = 1;
                if (m_fetch && !m_discard) m_inst = 32'h0;
                if (!m_fetch && m_we == 4'h0) m_dout = 32'h0;
                m_busy = 0;
            end else begin
                m_waited++;
                if (m_fetch && flush) m_discard = 1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
